am2940_dma_seq: RTL and testbench



---
 rtl/am2940_pkg.sv | 24 ++
 rtl/am2940_dma_seq_if.sv | 25 ++
 rtl/am2940_updown_cnt.sv | 31 +++
 rtl/am2940_dma_seq.sv | 122 ++++++++++++
 tb/tb_am2940_dma_seq.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/am2940_pkg.sv
// Shared opcode, mode and state definitions for the Am2940-style DMA sequencer.
package am2940_pkg;

  localparam logic [2:0] OP_WRCR   = 3'd0;
  localparam logic [2:0] OP_RDCR   = 3'd1;
  localparam logic [2:0] OP_RDWC   = 3'd2;
  localparam logic [2:0] OP_RDAC   = 3'd3;
  localparam logic [2:0] OP_REINIT = 3'd4;
  localparam logic [2:0] OP_LDAD   = 3'd5;
  localparam logic [2:0] OP_LDWC   = 3'd6;
  localparam logic [2:0] OP_ENCT   = 3'd7;

  localparam logic [1:0] MODE_WC_DEC = 2'd0;
  localparam logic [1:0] MODE_WC_CMP = 2'd1;
  localparam logic [1:0] MODE_AC_CMP = 2'd2;
  localparam logic [1:0] MODE_FREE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/am2940_dma_seq_if.sv
// Host/bus interface of the DMA sequencer: instruction port, step handshake, status.
interface am2940_dma_seq_if #(
  parameter int unsigned W = 4
);
  logic [2:0]   instr;
  logic         instr_vld;
  logic [W-1:0] di;
  logic         step;
  logic         step_rdy;
  logic [W-1:0] do_data;
  logic         do_vld;
  logic [W-1:0] addr;
  logic         done;
  logic [2:0]   ctrl_q;

  modport master (
    output instr, instr_vld, di, step,
    input  step_rdy, do_data, do_vld, addr, done, ctrl_q
  );

  modport slave (
    input  instr, instr_vld, di, step,
    output step_rdy, do_data, do_vld, addr, done, ctrl_q
  );
endinterface

// File: rtl/am2940_updown_cnt.sv
// W-bit loadable up/down counter; exposes the stepped value for terminal compare.
module am2940_updown_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         dir,   // 1: decrement
  output logic [W-1:0] q,
  output logic [W-1:0] nxt
);

  // Stepped value, wraps modulo 2^W.
  always_comb begin
    nxt = dir ? q - 1'b1 : q + 1'b1;
  end

  // Count register; load has priority over stepping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/am2940_dma_seq.sv
// Am2940-style DMA sequencer: host instruction decode, AR/AC/WR/WC/CR, terminal count.
module am2940_dma_seq
  import am2940_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input logic             clk,
  input logic             rst_n,
  am2940_dma_seq_if.slave bus
);

  state_e       state_q, state_d;
  logic [W-1:0] ar_q, wr_q, ac, wc, ac_nxt, wc_nxt;
  logic [2:0]   cr_q;
  logic [W-1:0] do_q;
  logic         do_vld_q;
  logic [1:0]   mode;
  logic         step_acc, term, ac_load, wc_load, cmp_mode;
  logic [W-1:0] ac_load_val, wc_load_val;

  assign mode     = cr_q[1:0];
  assign cmp_mode = (mode == MODE_WC_CMP) || (mode == MODE_AC_CMP);

  // Step acceptance, counter load controls and terminal detection on next values.
  always_comb begin
    bus.step_rdy = (state_q == ST_ARMED) && !bus.instr_vld;
    step_acc     = bus.step_rdy && bus.step;
    ac_load      = bus.instr_vld && (bus.instr == OP_REINIT || bus.instr == OP_LDAD);
    wc_load      = bus.instr_vld && (bus.instr == OP_REINIT || bus.instr == OP_LDWC);
    ac_load_val  = (bus.instr == OP_LDAD) ? bus.di : ar_q;
    // Compare modes count WC up from zero towards WR.
    wc_load_val  = cmp_mode ? '0 : ((bus.instr == OP_LDWC) ? bus.di : wr_q);
    term         = 1'b0;
    case (mode)
      MODE_WC_DEC: term = (wc_nxt == '0);
      MODE_WC_CMP: term = (wc_nxt == wr_q);
      MODE_AC_CMP: term = (ac_nxt == wr_q);
      default:     term = 1'b0;
    endcase
  end

  am2940_updown_cnt #(.W(W)) u_ac (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ac_load),
    .load_val (ac_load_val),
    .en       (step_acc),
    .dir      (cr_q[2]),
    .q        (ac),
    .nxt      (ac_nxt)
  );

  am2940_updown_cnt #(.W(W)) u_wc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wc_load),
    .load_val (wc_load_val),
    .en       (step_acc),
    .dir      (mode == MODE_WC_DEC),
    .q        (wc),
    .nxt      (wc_nxt)
  );

  // Next-state: instructions win over steps; loads/WRCR force IDLE, ENCT only arms from IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.instr_vld) begin
      case (bus.instr)
        OP_WRCR, OP_REINIT, OP_LDAD, OP_LDWC: state_d = ST_IDLE;
        OP_ENCT: if (state_q == ST_IDLE) state_d = ST_ARMED;
        default: state_d = state_q;
      endcase
    end else if (step_acc && term) begin
      state_d = ST_DONE;
    end
  end

  // Configuration registers, state and read-back pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ar_q     <= '0;
      wr_q     <= '0;
      cr_q     <= '0;
      do_q     <= '0;
      do_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      do_vld_q <= 1'b0;
      if (bus.instr_vld) begin
        case (bus.instr)
          OP_WRCR: cr_q <= bus.di[2:0];
          OP_RDCR: begin
            do_q     <= {{(W-3){1'b0}}, cr_q};
            do_vld_q <= 1'b1;
          end
          OP_RDWC: begin
            do_q     <= wc;
            do_vld_q <= 1'b1;
          end
          OP_RDAC: begin
            do_q     <= ac;
            do_vld_q <= 1'b1;
          end
          OP_LDAD: ar_q <= bus.di;
          OP_LDWC: wr_q <= bus.di;
          default: ;
        endcase
      end
    end
  end

  // Status outputs.
  always_comb begin
    bus.do_data = do_q;
    bus.do_vld  = do_vld_q;
    bus.addr    = ac;
    bus.done    = (state_q == ST_DONE);
    bus.ctrl_q  = cr_q;
  end

endmodule

// File: tb/tb_am2940_dma_seq.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_am2940_dma_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  am2940_dma_seq_if #(.W(4)) bus ();

  am2940_dma_seq #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state (architectural registers).
  logic [3:0] m_ar, m_ac, m_wr, m_wc, m_do;
  logic [2:0] m_cr;
  bit         m_dv;
  int         m_st;  // 0 idle, 1 armed, 2 done

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ar = 0; m_ac = 0; m_wr = 0; m_wc = 0; m_do = 0; m_cr = 0; m_dv = 0; m_st = 0;
  endtask

  // One clock: drive inputs, check step_rdy, advance model, compare registered outputs.
  task automatic cyc(input bit v, input logic [2:0] op, input logic [3:0] d, input bit s);
    bit         term;
    logic [1:0] mode;
    bus.instr_vld = v;
    bus.instr     = op;
    bus.di        = d;
    bus.step      = s;
    #1;
    chk("step_rdy", {7'd0, bus.step_rdy}, {7'd0, (m_st == 1) && !v});
    @(posedge clk);
    #1;
    mode = m_cr[1:0];
    if (!rst_n) begin
      model_reset();
    end else begin
      m_dv = 0;
      if (v) begin
        case (op)
          3'd0: begin m_cr = d[2:0]; m_st = 0; end
          3'd1: begin m_do = {1'b0, m_cr}; m_dv = 1; end
          3'd2: begin m_do = m_wc; m_dv = 1; end
          3'd3: begin m_do = m_ac; m_dv = 1; end
          3'd4: begin
            m_ac = m_ar;
            m_wc = (mode == 1 || mode == 2) ? 4'd0 : m_wr;
            m_st = 0;
          end
          3'd5: begin m_ar = d; m_ac = d; m_st = 0; end
          3'd6: begin
            m_wr = d;
            m_wc = (mode == 1 || mode == 2) ? 4'd0 : d;
            m_st = 0;
          end
          default: if (m_st == 0) m_st = 1;
        endcase
      end else if (s && m_st == 1) begin
        m_ac = m_cr[2] ? m_ac - 4'd1 : m_ac + 4'd1;
        m_wc = (mode == 0) ? m_wc - 4'd1 : m_wc + 4'd1;
        case (mode)
          2'd0: term = (m_wc == 0);
          2'd1: term = (m_wc == m_wr);
          2'd2: term = (m_ac == m_wr);
          default: term = 0;
        endcase
        if (term) m_st = 2;
      end
    end
    chk("addr", {4'd0, bus.addr}, {4'd0, m_ac});
    chk("done", {7'd0, bus.done}, {7'd0, m_st == 2});
    chk("ctrl_q", {5'd0, bus.ctrl_q}, {5'd0, m_cr});
    chk("do_vld", {7'd0, bus.do_vld}, {7'd0, m_dv});
    chk("do_data", {4'd0, bus.do_data}, {4'd0, m_do});
  endtask

  task automatic ins(input logic [2:0] op, input logic [3:0] d);
    cyc(1'b1, op, d, 1'b0);
  endtask

  task automatic stp();
    cyc(1'b0, 3'd0, 4'd0, 1'b1);
  endtask

  initial begin
    bus.instr_vld = 0; bus.instr = 0; bus.di = 0; bus.step = 0;
    model_reset();
    // 1: reset then reads
    rst_n = 0;
    cyc(1'b0, 3'd0, 4'd0, 1'b0);
    cyc(1'b1, 3'd7, 4'd5, 1'b1);
    rst_n = 1;
    ins(3'd1, 4'd0); chk("rst_rdcr", {4'd0, bus.do_data}, 8'h00);
    ins(3'd2, 4'd0); chk("rst_rdwc_vld", {7'd0, bus.do_vld}, 8'h01);
    ins(3'd3, 4'd0); chk("rst_rdac", {4'd0, bus.do_data}, 8'h00);
    chk("rst_done", {7'd0, bus.done}, 8'h00);
    // 2: mode 0 countdown
    ins(3'd0, 4'b0000); ins(3'd5, 4'b0011); ins(3'd6, 4'b0011); ins(3'd7, 4'd0);
    stp(); chk("m0_a1", {4'd0, bus.addr}, 8'h04);
    stp(); chk("m0_a2", {4'd0, bus.addr}, 8'h05);
    chk("m0_notdone", {7'd0, bus.done}, 8'h00);
    stp(); chk("m0_a3", {4'd0, bus.addr}, 8'h06);
    chk("m0_done", {7'd0, bus.done}, 8'h01);
    stp(); chk("m0_ignored", {4'd0, bus.addr}, 8'h06);
    // 6: re-arm
    ins(3'd7, 4'd0); chk("enct_in_done", {7'd0, bus.done}, 8'h01);
    ins(3'd4, 4'd0); chk("reinit_idle", {7'd0, bus.done}, 8'h00);
    chk("reinit_ac", {4'd0, bus.addr}, 8'h03);
    ins(3'd2, 4'd0); chk("reinit_wc", {4'd0, bus.do_data}, 8'h03);
    ins(3'd7, 4'd0);
    stp(); stp(); stp();
    chk("rearm_addr", {4'd0, bus.addr}, 8'h06);
    chk("rearm_done", {7'd0, bus.done}, 8'h01);
    // 3: decrement wrap, mode 2
    ins(3'd0, 4'b0110); ins(3'd5, 4'b0001); ins(3'd6, 4'b1110); ins(3'd7, 4'd0);
    stp(); chk("m2_a1", {4'd0, bus.addr}, 8'h00);
    stp(); chk("m2_a2", {4'd0, bus.addr}, 8'h0f);
    chk("m2_notdone", {7'd0, bus.done}, 8'h00);
    stp(); chk("m2_a3", {4'd0, bus.addr}, 8'h0e);
    chk("m2_done", {7'd0, bus.done}, 8'h01);
    // 5 with 4: mode 3 free run, collision first
    ins(3'd0, 4'b0011); ins(3'd6, 4'b0000); ins(3'd7, 4'd0);
    stp();
    cyc(1'b1, 3'd3, 4'd0, 1'b1);
    chk("coll_ac", {4'd0, bus.addr}, 8'h0f);
    chk("coll_do", {4'd0, bus.do_data}, 8'h0f);
    for (int i = 0; i < 19; i++) stp();
    chk("m3_done", {7'd0, bus.done}, 8'h00);
    chk("m3_addr", {4'd0, bus.addr}, 8'h02);
    ins(3'd2, 4'd0); chk("m3_wc", {4'd0, bus.do_data}, 8'h04);
    // Random traffic against the model, including occasional mid-run resets.
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cyc($urandom_range(0, 99) < 30, 3'($urandom), 4'($urandom), 1'($urandom));
    end
    rst_n = 1;
    cyc(1'b0, 3'd0, 4'd0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
